tlc5615_rx: RTL
===============

# tlc5615_rx

Serial-frame receiver for the DAC link: the far end of the 3-wire (cs/sclk/din) interface the modulator's DAC driver transmits on. It oversamples the link with the system clock, rebuilds each 12- or 16-bit frame, and delivers the 10-bit code word with a one-cycle valid strobe. It sits in the loopback/verification path beside the modulator top, so the ASK/FSK/PSK/DPSK sample stream can be captured and checked in-fabric without the external DAC.

## Interface
- SYNC_STAGES, 2: synchroniser flops on cs, sclk and din (legal range 2-3).
- FRAME_CNT_W, 16: width of the accepted-frame counter.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cs  input  1  link chip select, active low, asynchronous to clk.
- sclk  input  1  link serial clock, asynchronous to clk; data sampled on its rising edge.
- din  input  1  link serial data, MSB first.
- dac_code  output  10  last accepted code word.
- code_valid  output  1  one-cycle strobe: dac_code updated this cycle.
- frame_err  output  1  one-cycle strobe: frame rejected.
- frame_cnt  output  FRAME_CNT_W  count of accepted frames, wraps.

## Operation
- cs, sclk and din each pass through SYNC_STAGES flops, plus one history flop on cs and sclk for edge detection. Sync flops reset to cs=1, sclk=0, din=0.
- Edge detection is on synchronised signals only; din is sampled from its synchronised copy in the cycle the synchronised sclk rise is detected.
- FSM states:
  - ARM (reset state): wait for synchronised cs = 1, then go to IDLE. Ensures a frame already in progress when reset releases is ignored.
  - IDLE: on cs falling edge, clear shift register and bit counter, go to SHIFT.
  - SHIFT: on each sclk rising edge with cs low, shift din into the LSB of a 16-bit shift register and increment a 5-bit bit counter that saturates at 31. On cs rising edge, evaluate the frame and go to IDLE.
- Frame evaluation on cs rising edge:
  - bit count = 12 or 16: dac_code <= shift[11:2] (last 12 bits = D9..D0 plus two fill bits; fill bits ignored, leading 4 bits of a 16-bit frame ignored); code_valid = 1; frame_cnt increments, wrapping at 2^FRAME_CNT_W-1 -> 0.
  - any other count (including 0 and saturated counts): frame_err = 1; dac_code and frame_cnt hold.
- sclk edges while cs is high, or in ARM/IDLE, are ignored.
- Simultaneous events, same detection cycle:
  - cs falling + sclk rising: the frame starts, that sclk edge is not counted.
  - cs rising + sclk rising: the frame closes, that sclk edge is not counted.
- code_valid and frame_err are never high together.

## Timing
- Reset values: dac_code = 0, code_valid = 0, frame_err = 0, frame_cnt = 0; FSM in ARM; shift register and bit counter 0.
- Reset is asserted asynchronously and takes effect mid-frame; the partial frame is discarded and no strobe is issued.
- Latency: a pin-level cs rise produces code_valid/frame_err and the dac_code update SYNC_STAGES+1 clk cycles later. A pin-level sclk rise is captured in the shift register SYNC_STAGES+1 cycles later.
- Link requirements:
  - sclk high and sclk low each at least SYNC_STAGES+1 clk periods.
  - din stable from SYNC_STAGES+1 clk periods before to 1 period after each sclk rise.
  - cs high between frames at least SYNC_STAGES+1 periods.
- Violations yield undefined data but never a hang: the next valid cs high→low sequence recovers.
- Strobes are exactly one clk cycle wide.

## Test plan
- 12-bit frame, code 10'h2A5 (bits 1010100101_00), sclk = clk/8 -> code_valid one cycle, dac_code = 10'h2A5, frame_cnt = 1, 3 cycles after cs rise (SYNC_STAGES=2).
- 16-bit frame, 4 dummy 1s + 10'h3FF + 00, then 12-bit frame of 10'h000 -> dac_code 10'h3FF then 10'h000, frame_cnt = 2, no frame_err.
- 11-bit frame, then 17-bit frame, then 0-bit cs pulse -> three frame_err strobes, dac_code holds its prior value, frame_cnt unchanged.
- Assert reset_n low after 6 bits of a frame and release while cs is still low; finish that frame, then send 10'h155 -> no strobe for the interrupted frame; code_valid with dac_code = 10'h155, frame_cnt = 1.
- Toggle sclk 20 times with cs high, then force cs fall and sclk rise in the same sync cycle followed by 12 bits of 10'h0F0 -> dac_code = 10'h0F0, no spurious bit counted.
- Preload frame_cnt to 16'hFFFF via 65535 back-to-back frames, or force it in simulation; send one more valid frame -> frame_cnt = 0 with code_valid.

Source files
------------

// File: rtl/tlc5615_rx.sv
// tlc5615_rx: oversampling receiver for the 3-wire DAC link (cs/sclk/din).
// Rebuilds 12- or 16-bit frames and delivers the 10-bit code word with a
// one-cycle valid strobe; malformed frames produce a one-cycle error strobe.
//
// state  | meaning
// ARM    | after reset: flush synchronisers, then wait for cs high
// IDLE   | link idle, waiting for cs falling edge
// SHIFT  | frame open, shifting din on each sclk rise until cs rises
module tlc5615_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cs,
    input  logic                   sclk,
    input  logic                   din,
    output logic [9:0]             dac_code,
    output logic                   code_valid,
    output logic                   frame_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // The reset values of the synchronisers are not real link samples, so ARM
    // waits until every sync and history stage has been refilled from the pins.
    localparam logic [2:0] ARM_LOAD = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   cs_hist_q, cs_hist_d;
    logic                   sclk_hist_q, sclk_hist_d;

    state_t                 state_q, state_d;
    logic [2:0]             arm_cnt_q, arm_cnt_d;
    logic [15:0]            shift_q, shift_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             dac_code_q, dac_code_d;
    logic                   code_valid_q, code_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic cs_s, sclk_s, din_s;
    logic cs_fall, cs_rise, sclk_rise;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_hist_q & ~cs_s;
    assign cs_rise   = ~cs_hist_q & cs_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;

    // Synchroniser shift, edge history and frame FSM next-state logic.
    always_comb begin
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        din_sync_d   = {din_sync_q[SYNC_STAGES-2:0], din};
        cs_hist_d    = cs_s;
        sclk_hist_d  = sclk_s;
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dac_code_d   = dac_code_q;
        frame_cnt_d  = frame_cnt_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_ARM: begin
                if (arm_cnt_q != 3'd0) begin
                    arm_cnt_d = arm_cnt_q - 3'd1;
                end else if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // An sclk rise coinciding with the cs fall is deliberately dropped.
                if (cs_fall) begin
                    shift_d   = 16'd0;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cs rise wins over a coincident sclk rise: the frame closes first.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == 5'd12 || bit_cnt_q == 5'd16) begin
                        dac_code_d   = shift_q[11:2];
                        code_valid_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise && !cs_s) begin
                    shift_d = {shift_q[14:0], din_s};
                    if (bit_cnt_q != 5'd31) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q    <= '1;
            sclk_sync_q  <= '0;
            din_sync_q   <= '0;
            cs_hist_q    <= 1'b1;
            sclk_hist_q  <= 1'b0;
            state_q      <= ST_ARM;
            arm_cnt_q    <= ARM_LOAD;
            shift_q      <= 16'd0;
            bit_cnt_q    <= 5'd0;
            dac_code_q   <= 10'd0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            din_sync_q   <= din_sync_d;
            cs_hist_q    <= cs_hist_d;
            sclk_hist_q  <= sclk_hist_d;
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dac_code_q   <= dac_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dac_code   = dac_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
